regslv_param_array: RTL and testbench

Parametrised register-slave array that terminates a reg_native_if link from a regmst and holds REG_NUM internal registers, each with its own software access mode. It extends the fixed five-entry slave, which offered only r/rw/rw1/w/w1, with configurable depth, width, base address and acknowledge latency, two additional modes (write-1-to-clear, read-to-clear) and an optional error response. Each register also has a hardware port for updates and value observation.

---
 rtl/regslv_param_array.sv | 232 +++++++++++++++++++++++
 tb/tb_regslv_param_array.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regslv_param_array.sv
`default_nettype none
// ============================================================================
// Module   : regslv_param_array
// Brief    : Parametrised register-slave array terminating a reg_native_if
//            link. There are REG_NUM registers, each with its own software
//            access mode and a hardware load/observe port.
//            Optional error response: define REGSLV_PARAM_ARRAY_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regslv_param_array #(
  parameter int                             ADDR_WIDTH = 64,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             REG_NUM    = 8,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter logic [REG_NUM*3-1:0]           ACC_MODE   = {REG_NUM{3'd1}},
  parameter logic [REG_NUM*DATA_WIDTH-1:0]  RST_VAL    = '0,
  parameter int                             ACK_LAT    = 1
) (
  input  logic                          fsm_clk,
  input  logic                          soft_rst,
  input  logic                          req_vld,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          ack_vld,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          ack_err,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw_next_value,
  input  logic [REG_NUM-1:0]            hw_pulse,
  output logic [REG_NUM*DATA_WIDTH-1:0] hw_curr_value
);

  localparam logic [2:0] MODE_RO  = 3'd0;
  localparam logic [2:0] MODE_RW  = 3'd1;
  localparam logic [2:0] MODE_RW1 = 3'd2;
  localparam logic [2:0] MODE_WO  = 3'd3;
  localparam logic [2:0] MODE_W1  = 3'd4;
  localparam logic [2:0] MODE_W1C = 3'd5;
  localparam logic [2:0] MODE_RC  = 3'd6;

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m == 3'd7) ? MODE_RO : m;
  endfunction

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_rd_pend;

  logic [ADDR_WIDTH-1:0]   w_offset;
  logic [ADDR_WIDTH-1:0]   w_index;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_in_range;
  logic                    w_cap;
  logic                    w_sw_wr;
  logic                    w_sw_rd;
  logic [2:0]              w_sel_mode;
  logic [DATA_WIDTH-1:0]   w_sel_val;
  logic [DATA_WIDTH-1:0]   w_rd_val;

  // Address decode: below base, misaligned or past the last index is out of range.
  assign w_offset   = addr - BASE_ADDR;
  assign w_index    = w_offset >> ADDR_LSB;
  assign w_idx      = w_index[IDX_W-1:0];
  assign w_in_range = (addr >= BASE_ADDR) &&
                      (w_offset[ADDR_LSB-1:0] == '0) &&
                      (w_index < ADDR_WIDTH'(REG_NUM));

  assign w_cap   = (r_state == S_IDLE) && req_vld;
  assign w_sw_wr = w_cap && wr_en && !rd_en && w_in_range;
  assign w_sw_rd = w_cap && rd_en && !wr_en && w_in_range;

  always_comb begin
    w_sel_mode = MODE_RO;
    w_sel_val  = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_mode = norm_mode(ACC_MODE[i*3 +: 3]);
        w_sel_val  = hw_curr_value[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write-only flavours never expose their contents.
  assign w_rd_val = (w_sw_rd && (w_sel_mode != MODE_WO) && (w_sel_mode != MODE_W1))
                    ? w_sel_val : '0;

`ifdef REGSLV_PARAM_ARRAY_ERR_EN
  logic [REG_NUM-1:0] w_written;
`endif

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
    localparam logic [2:0] MODE = norm_mode(ACC_MODE[gi*3 +: 3]);

    logic [DATA_WIDTH-1:0] r_val;
    logic                  r_written;
    logic                  w_hit_wr;
    logic                  w_hit_rd;
    logic [DATA_WIDTH-1:0] w_hw_val;

    assign w_hit_wr = w_sw_wr && (w_idx == IDX_W'(gi));
    assign w_hit_rd = w_sw_rd && (w_idx == IDX_W'(gi));
    assign w_hw_val = hw_next_value[gi*DATA_WIDTH +: DATA_WIDTH];

    // Load modes let software win; clearing modes let hardware win so no event is lost.
    always_ff @(posedge fsm_clk) begin
      if (soft_rst) begin
        r_val     <= RST_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
        r_written <= 1'b0;
      end else begin
        case (MODE)
          MODE_RW, MODE_WO: begin
            if (w_hit_wr)          r_val <= wr_data;
            else if (hw_pulse[gi]) r_val <= w_hw_val;
          end
          MODE_RW1, MODE_W1: begin
            if (w_hit_wr && !r_written) begin
              r_val     <= wr_data;
              r_written <= 1'b1;
            end else if (hw_pulse[gi]) begin
              r_val <= w_hw_val;
            end
          end
          MODE_W1C: begin
            if (hw_pulse[gi])  r_val <= w_hw_val;
            else if (w_hit_wr) r_val <= r_val & ~wr_data;
          end
          MODE_RC: begin
            if (hw_pulse[gi])  r_val <= w_hw_val;
            else if (w_hit_rd) r_val <= '0;
          end
          default: begin
            if (hw_pulse[gi]) r_val <= w_hw_val;
          end
        endcase
      end
    end

    assign hw_curr_value[gi*DATA_WIDTH +: DATA_WIDTH] = r_val;
`ifdef REGSLV_PARAM_ARRAY_ERR_EN
    assign w_written[gi] = r_written;
`endif
  end

  always_ff @(posedge fsm_clk) begin
    if (soft_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      ack_vld   <= 1'b0;
      rd_data   <= '0;
      r_rd_pend <= '0;
    end else begin
      ack_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_vld) begin
            if (ACK_LAT == 1) begin
              r_state <= S_ACK;
              ack_vld <= 1'b1;
              rd_data <= w_rd_val;
            end else begin
              r_state   <= S_WAIT;
              r_cnt     <= 4'(ACK_LAT - 2);
              r_rd_pend <= w_rd_val;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ACK;
            ack_vld <= 1'b1;
            rd_data <= r_rd_pend;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef REGSLV_PARAM_ARRAY_ERR_EN
  logic w_sel_written;
  logic w_err;
  logic r_err_pend;

  always_comb begin
    w_sel_written = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (w_idx == IDX_W'(i)) w_sel_written = w_written[i];
    end
  end

  // Mode-dependent terms only matter in range; out of range already flags.
  always_comb begin
    w_err = !w_in_range || (wr_en && rd_en);
    if (wr_en && !rd_en && ((w_sel_mode == MODE_RO) || (w_sel_mode == MODE_RC)))
      w_err = 1'b1;
    if (rd_en && !wr_en && ((w_sel_mode == MODE_WO) || (w_sel_mode == MODE_W1)))
      w_err = 1'b1;
    if (wr_en && !rd_en && w_sel_written &&
        ((w_sel_mode == MODE_RW1) || (w_sel_mode == MODE_W1)))
      w_err = 1'b1;
  end

  always_ff @(posedge fsm_clk) begin
    if (soft_rst) begin
      ack_err    <= 1'b0;
      r_err_pend <= 1'b0;
    end else if (w_cap) begin
      if (ACK_LAT == 1) ack_err    <= w_err;
      else              r_err_pend <= w_err;
    end else if ((r_state == S_WAIT) && (r_cnt == 4'd0)) begin
      ack_err <= r_err_pend;
    end
  end
`else
  assign ack_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regslv_param_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_regslv_param_array
// Brief    : Randomised bench for regslv_param_array; two instances (ACK_LAT 1
//            and 4) share stimulus and are compared with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regslv_param_array;

  localparam logic [63:0]  BASE = 64'h100;
  localparam logic [23:0]  ACC  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [255:0] RST  = {32'h7777_0007, {7{32'h0}}};
  localparam int           MODE_OF [8] = '{0, 1, 2, 3, 4, 5, 6, 7};

  logic         fsm_clk = 1'b0;
  logic         soft_rst, req_a, req_b, wr_en, rd_en;
  logic [63:0]  addr;
  logic [31:0]  wr_data;
  logic [255:0] hw_next;
  logic [7:0]   hw_pulse;
  logic         ack_a, ack_b, err_a, err_b;
  logic [31:0]  rd_a, rd_b;
  logic [255:0] cur_a, cur_b;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  m_val [8];
  bit           m_wr  [8];

  always #5 fsm_clk = ~fsm_clk;

  regslv_param_array #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .REG_NUM(8), .BASE_ADDR(BASE),
                       .ACC_MODE(ACC), .RST_VAL(RST), .ACK_LAT(1)) dut_a (
    .fsm_clk(fsm_clk), .soft_rst(soft_rst), .req_vld(req_a), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .ack_vld(ack_a), .rd_data(rd_a), .ack_err(err_a),
    .hw_next_value(hw_next), .hw_pulse(hw_pulse), .hw_curr_value(cur_a));

  regslv_param_array #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .REG_NUM(8), .BASE_ADDR(BASE),
                       .ACC_MODE(ACC), .RST_VAL(RST), .ACK_LAT(4)) dut_b (
    .fsm_clk(fsm_clk), .soft_rst(soft_rst), .req_vld(req_b), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .ack_vld(ack_b), .rd_data(rd_b), .ack_err(err_b),
    .hw_next_value(hw_next), .hw_pulse(hw_pulse), .hw_curr_value(cur_b));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = m_val[i];
    return f;
  endfunction

  task automatic model_reset();
    logic [255:0] r;
    r = RST;
    for (int i = 0; i < 8; i++) begin
      m_val[i] = r[i*32 +: 32];
      m_wr[i]  = 1'b0;
    end
  endtask

  // Behavioural view of one captured request plus concurrent hardware pulses.
  task automatic model_txn(input bit wr, input bit rd, input logic [63:0] a,
                           input logic [31:0] d, input logic [7:0] pulse,
                           input logic [255:0] nxt, output logic [31:0] erd, output bit eerr);
    logic [63:0] off;
    bit          inr, acc_wr, acc_rd;
    int          idx, md;
    off    = a - BASE;
    inr    = (a >= BASE) && (off[1:0] == 2'b00) && ((off >> 2) < 64'd8);
    idx    = inr ? int'(off >> 2) : -1;
    acc_wr = wr && !rd && inr;
    acc_rd = rd && !wr && inr;
    erd    = 32'h0;
    eerr   = !inr || (wr && rd);
    if (inr) begin
      md = (MODE_OF[idx] == 7) ? 0 : MODE_OF[idx];
      if (acc_rd && md != 3 && md != 4) erd = m_val[idx];
      if (acc_wr && (md == 0 || md == 6)) eerr = 1'b1;
      if (acc_rd && (md == 3 || md == 4)) eerr = 1'b1;
      if (acc_wr && (md == 2 || md == 4) && m_wr[idx]) eerr = 1'b1;
    end
`ifndef REGSLV_PARAM_ARRAY_ERR_EN
    eerr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      bit          sw_w, sw_r, hp;
      logic [31:0] hv;
      int          mi;
      mi   = (MODE_OF[i] == 7) ? 0 : MODE_OF[i];
      sw_w = acc_wr && (idx == i);
      sw_r = acc_rd && (idx == i);
      hp   = pulse[i];
      hv   = nxt[i*32 +: 32];
      case (mi)
        1, 3: if (sw_w) m_val[i] = d; else if (hp) m_val[i] = hv;
        2, 4: begin
          if (sw_w && !m_wr[i]) begin m_val[i] = d; m_wr[i] = 1'b1; end
          else if (hp) m_val[i] = hv;
        end
        5: if (hp) m_val[i] = hv; else if (sw_w) m_val[i] = m_val[i] & ~d;
        6: if (hp) m_val[i] = hv; else if (sw_r) m_val[i] = 32'h0;
        default: if (hp) m_val[i] = hv;
      endcase
    end
  endtask

  // One request to both instances; B additionally gets a stray request in WAIT.
  task automatic txn(input bit wr, input bit rd, input logic [63:0] a, input logic [31:0] d,
                     input logic [7:0] pulse, input logic [255:0] nxt);
    logic [31:0] erd;
    bit          eerr;
    @(negedge fsm_clk);
    req_a = 1'b1; req_b = 1'b1; wr_en = wr; rd_en = rd; addr = a; wr_data = d;
    hw_pulse = pulse; hw_next = nxt;
    model_txn(wr, rd, a, d, pulse, nxt, erd, eerr);
    @(negedge fsm_clk);
    req_a = 1'b0; req_b = 1'b0; hw_pulse = 8'h0;
    chk("a_ack", ack_a, 1'b1);
    chk("a_rd", rd_a, erd);
    chk("a_err", err_a, eerr);
    chk("b_ack_early1", ack_b, 1'b0);
    chk("a_hw", cur_a, model_flat());
    chk("b_hw", cur_b, model_flat());
    @(negedge fsm_clk);
    chk("a_ack_pulse", ack_a, 1'b0);
    chk("b_ack_early2", ack_b, 1'b0);
    req_b = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = BASE + 64'd4; wr_data = $urandom;
    @(negedge fsm_clk);
    req_b = 1'b0;
    chk("b_ack_early3", ack_b, 1'b0);
    @(negedge fsm_clk);
    chk("b_ack", ack_b, 1'b1);
    chk("b_rd", rd_b, erd);
    chk("b_err", err_b, eerr);
    @(negedge fsm_clk);
    chk("b_ack_pulse", ack_b, 1'b0);
    chk("b_stray_ignored", cur_b, model_flat());
  endtask

  function automatic logic [63:0] ra(input int idx);
    return BASE + 64'(idx) * 64'd4;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] nxt;
    logic [63:0]  a;
    int           sel, k;
    soft_rst = 1'b1; req_a = 1'b0; req_b = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wr_data = '0; hw_next = '0; hw_pulse = '0;
    model_reset();
    repeat (3) @(negedge fsm_clk);
    soft_rst = 1'b0;
    chk("rst_ack_a", ack_a, 1'b0);
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_err_a", err_a, 1'b0);
    chk("rst_ack_b", ack_b, 1'b0);
    chk("rst_hw_a", cur_a, RST);
    chk("rst_hw_b", cur_b, RST);

    // Mode sweep
    txn(1, 0, ra(0), 32'hffff_ffff, 8'h0, '0);
    chk("ro_hw", cur_a[31:0], 32'h0);
    txn(0, 1, ra(0), 32'h0, 8'h0, '0);
    txn(1, 0, ra(1), 32'hffff_ffff, 8'h0, '0);
    txn(0, 1, ra(1), 32'h0, 8'h0, '0);
    chk("rw_rd", rd_a, 32'hffff_ffff);
    txn(1, 0, ra(1), 32'h1234_5678, 8'h0, '0);
    chk("rw_hw", cur_a[63:32], 32'h1234_5678);
    txn(1, 0, ra(2), 32'hffff_ffff, 8'h0, '0);
    txn(0, 1, ra(2), 32'h0, 8'h0, '0);
    txn(1, 0, ra(2), 32'h1234_5678, 8'h0, '0);
    chk("rw1_hw", cur_a[95:64], 32'hffff_ffff);
    txn(1, 0, ra(3), 32'hffff_ffff, 8'h0, '0);
    chk("wo_hw", cur_a[127:96], 32'hffff_ffff);
    txn(0, 1, ra(3), 32'h0, 8'h0, '0);
    chk("wo_rd", rd_a, 32'h0);
    txn(1, 0, ra(4), 32'hffff_ffff, 8'h0, '0);
    txn(0, 1, ra(4), 32'h0, 8'h0, '0);
    txn(1, 0, ra(4), 32'h1234_5678, 8'h0, '0);
    chk("w1_hw", cur_a[159:128], 32'hffff_ffff);
    nxt = '0; nxt[191:160] = 32'hff; nxt[223:192] = 32'hff;
    txn(0, 1, ra(0), 32'h0, 8'h60, nxt);
    txn(1, 0, ra(5), 32'h0000_000f, 8'h0, '0);
    chk("w1c_hw", cur_a[191:160], 32'h0000_00f0);
    txn(0, 1, ra(6), 32'h0, 8'h0, '0);
    chk("rc_rd", rd_a, 32'h0000_00ff);
    chk("rc_hw", cur_a[223:192], 32'h0);

    // Simultaneous software and hardware events
    nxt = '0; nxt[63:32] = 32'h2;
    txn(1, 0, ra(1), 32'h1, 8'h02, nxt);
    chk("sim_rw", cur_a[63:32], 32'h1);
    nxt = '0; nxt[191:160] = 32'hff;
    txn(0, 1, ra(0), 32'h0, 8'h20, nxt);
    nxt[191:160] = 32'h55;
    txn(1, 0, ra(5), 32'hffff_ffff, 8'h20, nxt);
    chk("sim_w1c", cur_a[191:160], 32'h55);

    // Address edge cases and qualifier combinations
    txn(0, 1, 64'h120, 32'h0, 8'h0, '0);
    chk("oor_rd", rd_a, 32'h0);
    txn(1, 0, 64'h105, 32'hdead_beef, 8'h0, '0);
    txn(0, 1, 64'h0fc, 32'h0, 8'h0, '0);
    txn(1, 1, ra(1), 32'hcafe_f00d, 8'h0, '0);
    txn(0, 0, ra(1), 32'hcafe_f00d, 8'h0, '0);

    // Reset during WAIT aborts B's request
    @(negedge fsm_clk);
    req_b = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = ra(1);
    @(negedge fsm_clk);
    req_b = 1'b0; rd_en = 1'b0;
    @(negedge fsm_clk);
    soft_rst = 1'b1;
    @(negedge fsm_clk);
    soft_rst = 1'b0;
    model_reset();
    chk("abort_hw_a", cur_a, RST);
    chk("abort_hw_b", cur_b, RST);
    chk("abort_rd_b", rd_b, 32'h0);
    for (int c = 0; c < 5; c++) begin
      chk("abort_no_ack", ack_b, 1'b0);
      @(negedge fsm_clk);
    end
    txn(1, 0, ra(2), 32'habcd_0123, 8'h0, '0);
    chk("rw1_after_rst", cur_a[95:64], 32'habcd_0123);

    // Randomised traffic
    for (int t = 0; t < 150; t++) begin
      for (int w = 0; w < 8; w++) nxt[w*32 +: 32] = $urandom;
      sel = $urandom_range(0, 9);
      k   = $urandom_range(0, 15);
      a   = ra($urandom_range(0, 9));
      if (k == 0) a = 64'h0fc;
      else if (k < 3) a = a + 64'($urandom_range(1, 3));
      txn(sel < 4 || sel == 8, (sel >= 4 && sel < 8) || sel == 8, a,
          ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : 32'($urandom),
          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0, nxt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
